// File: rtl/uart_boot_loader.sv
// ============================================================================
// uart_boot_loader
// ----------------------------------------------------------------------------
// Receives a program image over a UART line and writes it into a 16-bit-wide
// program memory. It holds the CPU off (boot_mode=1) until a full frame with
// a matching checksum has been written.
//
// Frame: 0x55, N (word count 1..255), N x {lo, hi}, checksum
//        checksum = 8-bit sum of the 2N data bytes.
//
// Ports
//   clk        in   system clock, all logic on its rising edge
//   rst_n      in   synchronous active-low reset
//   uart_rx    in   asynchronous serial input, idle high, 8N1, LSB first
//   mem_ce     out  memory chip enable, tied high
//   mem_wre    out  one-cycle write strobe per received word
//   mem_ad     out  write address (word index within the frame)
//   mem_din    out  write data {hi, lo}
//   boot_mode  out  high while loading; drops on a successful load
//   boot_done  out  one-cycle pulse on a successful load
//   boot_err   out  sticky error flag, cleared only by reset
// ============================================================================
module uart_boot_loader #(
    parameter int CLK_HZ       = 27000000,
    parameter int BAUD         = 115200,
    parameter int ADDR_W       = 11,
    parameter int TIMEOUT_CLKS = 27000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_rx,
    output logic              mem_ce,
    output logic              mem_wre,
    output logic [ADDR_W-1:0] mem_ad,
    output logic [15:0]       mem_din,
    output logic              boot_mode,
    output logic              boot_done,
    output logic              boot_err
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int TO_W         = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT_CLKS);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        S_WAIT_SYNC,
        S_GET_LEN,
        S_GET_LO,
        S_GET_HI,
        S_GET_SUM,
        S_DONE
    } frame_state_t;

    // ------------------------------------------------------------------------
    // Input synchronizer and falling-edge detect
    // ------------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_sync;
    logic r_rx_prev;
    logic w_rx_fall;

    // NOTE: the first flop may go metastable; only r_rx_sync is ever used.
    // Reset to the idle (high) level so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_rx_fall = r_rx_prev & ~r_rx_sync;

    // ------------------------------------------------------------------------
    // Byte receiver
    // ------------------------------------------------------------------------
    rx_state_t        r_rx_state;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_byte;
    logic             r_byte_vld;
    logic             r_stop_err;

    // NOTE: every sequential block uses non-blocking assignments so that all
    // registers update together from the values present before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_state <= RX_IDLE;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_byte     <= '0;
            r_byte_vld <= 1'b0;
            r_stop_err <= 1'b0;
        end else begin
            r_byte_vld <= 1'b0;
            r_stop_err <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_clk_cnt <= '0;
                    if (w_rx_fall) begin
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    // Mid-start re-check: a line that is high again was a glitch.
                    if (r_clk_cnt == HALF_LAST) begin
                        r_clk_cnt  <= '0;
                        r_bit_idx  <= '0;
                        r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_clk_cnt == BIT_LAST) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_clk_cnt == BIT_LAST) begin
                        r_clk_cnt  <= '0;
                        r_rx_state <= RX_IDLE;
                        if (r_rx_sync) begin
                            r_byte     <= r_shift;
                            r_byte_vld <= 1'b1;
                        end else begin
                            r_stop_err <= 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Frame FSM with registered memory and status outputs
    // ------------------------------------------------------------------------
    frame_state_t      r_state;
    logic [7:0]        r_len;
    logic [8:0]        r_word_idx;
    logic [7:0]        r_lo_byte;
    logic [7:0]        r_sum;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_mem_wre;
    logic [ADDR_W-1:0] r_mem_ad;
    logic [15:0]       r_mem_din;
    logic              r_boot_mode;
    logic              r_boot_done;
    logic              r_boot_err;
    logic [8:0]        w_next_idx;

    // Nine bits so that N=255 still compares correctly after the last word.
    assign w_next_idx = r_word_idx + 9'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_WAIT_SYNC;
            r_len       <= '0;
            r_word_idx  <= '0;
            r_lo_byte   <= '0;
            r_sum       <= '0;
            r_to_cnt    <= '0;
            r_mem_wre   <= 1'b0;
            r_mem_ad    <= '0;
            r_mem_din   <= '0;
            r_boot_mode <= 1'b1;
            r_boot_done <= 1'b0;
            r_boot_err  <= 1'b0;
        end else begin
            r_mem_wre   <= 1'b0;
            r_boot_done <= 1'b0;

            // Inter-byte gap counter, live only inside a frame; saturates.
            if (r_state == S_WAIT_SYNC || r_state == S_DONE || r_byte_vld) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != TO_MAX) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (r_state != S_DONE) begin
                if (r_stop_err) begin
                    r_boot_err <= 1'b1;
                    r_state    <= S_WAIT_SYNC;
                end else if (r_byte_vld) begin
                    case (r_state)
                        S_WAIT_SYNC: begin
                            if (r_byte == 8'h55) begin
                                r_sum      <= '0;
                                r_word_idx <= '0;
                                r_state    <= S_GET_LEN;
                            end
                        end
                        S_GET_LEN: begin
                            if (r_byte == 8'h00) begin
                                r_boot_err <= 1'b1;
                                r_state    <= S_WAIT_SYNC;
                            end else begin
                                r_len   <= r_byte;
                                r_state <= S_GET_LO;
                            end
                        end
                        S_GET_LO: begin
                            r_lo_byte <= r_byte;
                            r_sum     <= r_sum + r_byte;
                            r_state   <= S_GET_HI;
                        end
                        S_GET_HI: begin
                            r_mem_wre  <= 1'b1;
                            r_mem_ad   <= ADDR_W'(r_word_idx);
                            r_mem_din  <= {r_byte, r_lo_byte};
                            r_sum      <= r_sum + r_byte;
                            r_word_idx <= w_next_idx;
                            r_state    <= (w_next_idx == {1'b0, r_len}) ? S_GET_SUM : S_GET_LO;
                        end
                        S_GET_SUM: begin
                            if (r_byte == r_sum) begin
                                r_boot_mode <= 1'b0;
                                r_boot_done <= 1'b1;
                                r_state     <= S_DONE;
                            end else begin
                                // Words already written stay in memory.
                                r_boot_err <= 1'b1;
                                r_state    <= S_WAIT_SYNC;
                            end
                        end
                        default: r_state <= S_WAIT_SYNC;
                    endcase
                end else if (r_state != S_WAIT_SYNC && r_to_cnt == TO_MAX) begin
                    r_boot_err <= 1'b1;
                    r_state    <= S_WAIT_SYNC;
                end
            end
        end
    end

    assign mem_ce    = 1'b1;
    assign mem_wre   = r_mem_wre;
    assign mem_ad    = r_mem_ad;
    assign mem_din   = r_mem_din;
    assign boot_mode = r_boot_mode;
    assign boot_done = r_boot_done;
    assign boot_err  = r_boot_err;

endmodule

// File: tb/tb_uart_boot_loader.sv
// ============================================================================
// tb_uart_boot_loader
// ----------------------------------------------------------------------------
// Drives UART frames into uart_boot_loader and compares the memory writes and
// status flags against a frame-level reference model (frame parsing and
// checksum computed directly from the byte list).
// ============================================================================
module tb_uart_boot_loader;

    localparam int CPB    = 10;
    localparam int ADDR_W = 11;

    typedef struct {
        logic [ADDR_W-1:0] ad;
        logic [15:0]       din;
    } wr_t;
    typedef logic [7:0] bytes_t[$];
    typedef wr_t        wrs_t[$];

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              uart_rx = 1'b1;
    logic              mem_ce;
    logic              mem_wre;
    logic [ADDR_W-1:0] mem_ad;
    logic [15:0]       mem_din;
    logic              boot_mode;
    logic              boot_done;
    logic              boot_err;

    int n_vec = 0;
    int n_err = 0;

    uart_boot_loader #(
        .CLK_HZ      (1000000),
        .BAUD        (100000),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CLKS(500)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .uart_rx  (uart_rx),
        .mem_ce   (mem_ce),
        .mem_wre  (mem_wre),
        .mem_ad   (mem_ad),
        .mem_din  (mem_din),
        .boot_mode(boot_mode),
        .boot_done(boot_done),
        .boot_err (boot_err)
    );

    always #5 clk = ~clk;

    // Observation log, sampled on the falling edge.
    wr_t  wr_q[$];
    int   done_cnt = 0;
    int   done_long = 0;
    int   done_mode_bad = 0;
    int   wre_in_run = 0;
    int   ce_low = 0;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        if (mem_wre) begin
            wr_q.push_back('{mem_ad, mem_din});
            if (!boot_mode) wre_in_run++;
        end
        if (boot_done) begin
            done_cnt++;
            if (prev_done) done_long++;
            if (boot_mode) done_mode_bad++;
        end
        if (mem_ce !== 1'b1) ce_low++;
        prev_done = boot_done;
    end

    // ---------------------------------------------------------------- model
    function automatic wrs_t model_writes(input bytes_t f);
        wrs_t w;
        int   n;
        if (f.size() < 2 || f[0] != 8'h55 || f[1] == 8'h00) return w;
        n = int'(f[1]);
        for (int k = 0; k < n && 3 + 2 * k < f.size(); k++)
            w.push_back('{ADDR_W'(k), {f[3+2*k], f[2+2*k]}});
        return w;
    endfunction

    function automatic bit model_ok(input bytes_t f);
        int n;
        int s = 0;
        if (f.size() < 2) return 1'b0;
        n = int'(f[1]);
        if (f[0] != 8'h55 || n == 0 || f.size() != 2 * n + 3) return 1'b0;
        for (int k = 0; k < 2 * n; k++) s += int'(f[2+k]);
        return (s % 256) == int'(f[2*n+2]);
    endfunction

    function automatic int first_diff(input wrs_t exp);
        int n = (exp.size() > wr_q.size()) ? exp.size() : wr_q.size();
        for (int i = 0; i < n; i++) begin
            if (i >= exp.size() || i >= wr_q.size()) return i;
            if (exp[i].ad !== wr_q[i].ad || exp[i].din !== wr_q[i].din) return i;
        end
        return -1;
    endfunction

    function automatic string wr_str(input wrs_t q, input int i);
        if (i >= 0 && i < q.size()) return $sformatf("(%0d,%04h)", q[i].ad, q[i].din);
        return "none";
    endfunction

    // ------------------------------------------------------------ stimulus
    task automatic line_bit(input logic v);
        uart_rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(b[i]);
        line_bit(stop);
        uart_rx = 1'b1;
    endtask

    task automatic send_frame(input bytes_t f);
        foreach (f[i]) send_byte(f[i], 1'b1);
        repeat (20) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        wr_q.delete();
        done_cnt = 0;
    endtask

    // --------------------------------------------------------------- tests
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        n_vec++;
        if ({mem_ce, mem_wre, boot_mode, boot_done, boot_err} !== 5'b10100) begin
            n_err++;
            $display("FAIL reset_flags: got ce,wre,mode,done,err=%b want 10100",
                     {mem_ce, mem_wre, boot_mode, boot_done, boot_err});
        end
        n_vec++;
        if (mem_ad !== '0 || mem_din !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_mem: got ad=%0d din=%04h want ad=0 din=0000", mem_ad, mem_din);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_good_frame();
        bytes_t f;
        wrs_t   exp;
        int     d;
        do_reset();
        f = {8'h55, 8'h02, 8'hA1, 8'h00, 8'h78, 8'h00, 8'h19};
        exp = model_writes(f);
        send_frame(f);
        d = first_diff(exp);
        n_vec++;
        if (d >= 0) begin
            n_err++;
            $display("FAIL good_writes: entry %0d got %s want %s", d, wr_str(wr_q, d), wr_str(exp, d));
        end
        n_vec++;
        if (done_cnt != 1 || boot_mode !== 1'b0 || boot_err !== 1'b0) begin
            n_err++;
            $display("FAIL good_status: got done=%0d mode=%b err=%b want done=1 mode=0 err=0",
                     done_cnt, boot_mode, boot_err);
        end
        // Once loaded, further traffic is ignored.
        f = {8'h55, 8'h01, 8'hAA, 8'hBB, 8'h65};
        send_frame(f);
        n_vec++;
        if (wr_q.size() != exp.size() || done_cnt != 1 || boot_mode !== 1'b0) begin
            n_err++;
            $display("FAIL done_ignore: got writes=%0d done=%0d mode=%b want writes=%0d done=1 mode=0",
                     wr_q.size(), done_cnt, boot_mode, exp.size());
        end
    endtask

    task automatic test_bad_sum();
        bytes_t f;
        wrs_t   exp;
        int     d;
        do_reset();
        f = {8'h55, 8'h01, 8'h34, 8'h12, 8'h00};
        exp = model_writes(f);
        send_frame(f);
        d = first_diff(exp);
        n_vec++;
        if (d >= 0) begin
            n_err++;
            $display("FAIL badsum_writes: entry %0d got %s want %s", d, wr_str(wr_q, d), wr_str(exp, d));
        end
        n_vec++;
        if (boot_err !== 1'b1 || boot_mode !== 1'b1 || done_cnt != 0) begin
            n_err++;
            $display("FAIL badsum_status: got err=%b mode=%b done=%0d want err=1 mode=1 done=0",
                     boot_err, boot_mode, done_cnt);
        end
        wr_q.delete();
        f = {8'h55, 8'h01, 8'h34, 8'h12, 8'h46};
        exp = model_writes(f);
        send_frame(f);
        d = first_diff(exp);
        n_vec++;
        if (d >= 0) begin
            n_err++;
            $display("FAIL retry_writes: entry %0d got %s want %s", d, wr_str(wr_q, d), wr_str(exp, d));
        end
        n_vec++;
        if (boot_err !== 1'b1 || boot_mode !== 1'b0 || done_cnt != 1) begin
            n_err++;
            $display("FAIL retry_status: got err=%b mode=%b done=%0d want err=1 mode=0 done=1",
                     boot_err, boot_mode, done_cnt);
        end
    endtask

    task automatic test_zero_len();
        bytes_t f;
        do_reset();
        f = {8'h55, 8'h00};
        send_frame(f);
        n_vec++;
        if (boot_err !== 1'b1 || wr_q.size() != 0 || boot_mode !== 1'b1) begin
            n_err++;
            $display("FAIL zero_len: got err=%b writes=%0d mode=%b want err=1 writes=0 mode=1",
                     boot_err, wr_q.size(), boot_mode);
        end
    endtask

    task automatic test_glitch();
        bytes_t f;
        wrs_t   exp;
        int     d;
        do_reset();
        send_byte(8'h55, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (20) @(negedge clk);
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        f = {8'h34, 8'h12, 8'h46};
        send_frame(f);
        exp = model_writes({8'h55, 8'h01, 8'h34, 8'h12, 8'h46});
        d = first_diff(exp);
        n_vec++;
        if (d >= 0) begin
            n_err++;
            $display("FAIL glitch_writes: entry %0d got %s want %s", d, wr_str(wr_q, d), wr_str(exp, d));
        end
        n_vec++;
        if (boot_err !== 1'b0 || done_cnt != 1) begin
            n_err++;
            $display("FAIL glitch_status: got err=%b done=%0d want err=0 done=1", boot_err, done_cnt);
        end
    endtask

    task automatic test_stop_err();
        bytes_t f;
        do_reset();
        send_byte(8'h55, 1'b1);
        send_byte(8'h02, 1'b0);
        repeat (20) @(negedge clk);
        n_vec++;
        if (boot_err !== 1'b1) begin
            n_err++;
            $display("FAIL stop_err_flag: got err=%b want 1", boot_err);
        end
        // Back in WAIT_SYNC, so a headless frame must not be taken as a length.
        f = {8'h01, 8'h34, 8'h12, 8'h46};
        send_frame(f);
        n_vec++;
        if (wr_q.size() != 0 || done_cnt != 0) begin
            n_err++;
            $display("FAIL stop_err_sync: got writes=%0d done=%0d want writes=0 done=0",
                     wr_q.size(), done_cnt);
        end
    endtask

    task automatic test_timeout();
        bytes_t f;
        wrs_t   exp;
        int     d;
        // A gap well inside the limit must not trip the timeout.
        do_reset();
        send_byte(8'h55, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (300) @(negedge clk);
        f = {8'h34, 8'h12, 8'h46};
        send_frame(f);
        n_vec++;
        if (boot_err !== 1'b0 || done_cnt != 1) begin
            n_err++;
            $display("FAIL short_gap: got err=%b done=%0d want err=0 done=1", boot_err, done_cnt);
        end
        do_reset();
        send_byte(8'h55, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (600) @(negedge clk);
        n_vec++;
        if (boot_err !== 1'b1 || wr_q.size() != 0) begin
            n_err++;
            $display("FAIL timeout_flag: got err=%b writes=%0d want err=1 writes=0", boot_err, wr_q.size());
        end
        f = {8'h55, 8'h01, 8'hCD, 8'hAB, 8'h78};
        exp = model_writes(f);
        send_frame(f);
        d = first_diff(exp);
        n_vec++;
        if (d >= 0 || done_cnt != 1) begin
            n_err++;
            $display("FAIL timeout_reload: entry %0d got %s want %s done=%0d want 1",
                     d, wr_str(wr_q, d), wr_str(exp, d), done_cnt);
        end
    endtask

    task automatic test_reset_mid_byte();
        bytes_t f;
        wrs_t   exp;
        int     d;
        do_reset();
        send_byte(8'h55, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        line_bit(1'b0);
        repeat (3) line_bit(1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({mem_wre, boot_mode, boot_done, boot_err} !== 4'b0100 || mem_ad !== '0 || mem_din !== 16'h0000) begin
            n_err++;
            $display("FAIL midbyte_reset: got wre,mode,done,err=%b ad=%0d din=%04h want 0100 ad=0 din=0000",
                     {mem_wre, boot_mode, boot_done, boot_err}, mem_ad, mem_din);
        end
        rst_n   = 1'b1;
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        wr_q.delete();
        done_cnt = 0;
        f = {8'h55, 8'h01, 8'hFF, 8'hFF, 8'hFE};
        exp = model_writes(f);
        send_frame(f);
        d = first_diff(exp);
        n_vec++;
        if (d >= 0 || done_cnt != 1 || boot_mode !== 1'b0) begin
            n_err++;
            $display("FAIL midbyte_reload: entry %0d got %s want %s done=%0d mode=%b",
                     d, wr_str(wr_q, d), wr_str(exp, d), done_cnt, boot_mode);
        end
    endtask

    task automatic test_random_frames();
        for (int it = 0; it < 6; it++) begin
            bytes_t     f;
            wrs_t       exp;
            int         n;
            int         s;
            int         d;
            bit         ok;
            logic [7:0] b;
            do_reset();
            n = $urandom_range(1, 6);
            s = 0;
            f = {8'h55, 8'(n)};
            for (int k = 0; k < 2 * n; k++) begin
                b = 8'($urandom_range(0, 255));
                s += int'(b);
                f.push_back(b);
            end
            if ($urandom_range(0, 2) == 0) s += $urandom_range(1, 255);
            f.push_back(8'(s));
            exp = model_writes(f);
            ok  = model_ok(f);
            send_frame(f);
            d = first_diff(exp);
            n_vec++;
            if (d >= 0) begin
                n_err++;
                $display("FAIL rand%0d_writes: entry %0d got %s want %s", it, d, wr_str(wr_q, d), wr_str(exp, d));
            end
            n_vec++;
            if (done_cnt != int'(ok) || boot_mode !== !ok || boot_err !== !ok) begin
                n_err++;
                $display("FAIL rand%0d_status: got done=%0d mode=%b err=%b want done=%0d mode=%b err=%b",
                         it, done_cnt, boot_mode, boot_err, int'(ok), !ok, !ok);
            end
        end
    endtask

    task automatic test_invariants();
        n_vec++;
        if (done_long != 0 || done_mode_bad != 0 || wre_in_run != 0 || ce_low != 0) begin
            n_err++;
            $display("FAIL invariants: got long_done=%0d done_with_mode=%0d wre_after_load=%0d ce_low=%0d want all 0",
                     done_long, done_mode_bad, wre_in_run, ce_low);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_sum();
        test_zero_len();
        test_glitch();
        test_stop_err();
        test_timeout();
        test_reset_mid_byte();
        test_random_frames();
        test_invariants();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_boot_loader.md
UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

Interface
REQ-001 Parameter CLK_HZ, default 27000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD, integer division.
REQ-003 Parameter ADDR_W, default 11, program memory address width.
REQ-004 Parameter TIMEOUT_CLKS, default 27000000, maximum idle gap between bytes inside a frame.
REQ-005 clk  input  1  system clock; single clock domain, all logic on posedge clk.
REQ-006 rst_n  input  1  reset; synchronous, active-low.
REQ-007 uart_rx  input  1  asynchronous serial input, idle high, 8N1, LSB first.
REQ-008 mem_ce  output  1  memory chip enable, constant 1.
REQ-009 mem_wre  output  1  memory write strobe, one-cycle pulse per word.
REQ-010 mem_ad  output  ADDR_W  memory write address.
REQ-011 mem_din  output  16  memory write data.
REQ-012 boot_mode  output  1  high while loading; memory address mux and CPU hold use this signal.
REQ-013 boot_done  output  1  one-cycle pulse on successful load.
REQ-014 boot_err  output  1  sticky error flag.

Function
REQ-015 uart_rx SHALL pass through a 2-flop synchronizer before any use.
REQ-016 Receiver SHALL detect a start bit on a synchronized high-to-low transition while receiver idle.
REQ-017 Receiver SHALL re-sample at CLKS_PER_BIT/2 after the edge and return to idle if the line is high (glitch).
REQ-018 Receiver SHALL sample the 8 data bits and the stop bit at CLKS_PER_BIT intervals from the mid-start sample.
REQ-019 A stop bit sampled as 0 SHALL discard the byte, set boot_err, and return the frame FSM to WAIT_SYNC.
REQ-020 A valid byte SHALL raise an internal byte strobe for exactly one cycle.
REQ-021 Frame format: sync 0x55, length N (word count, 1..255), N words as low byte then high byte, checksum byte.
REQ-022 Frame FSM states: WAIT_SYNC, GET_LEN, GET_LO, GET_HI, GET_SUM, DONE.
REQ-023 WAIT_SYNC: 0x55 -> GET_LEN, clears checksum accumulator and word index; any other byte is ignored.
REQ-024 GET_LEN: N=0 -> set boot_err, go to WAIT_SYNC; otherwise latch N, go to GET_LO.
REQ-025 GET_LO latches the low byte and goes to GET_HI.
REQ-026 GET_HI: the cycle after the high byte strobe, mem_wre=1, mem_ad=word index, mem_din={hi,lo}, for one cycle.
REQ-027 After that write, the word index SHALL increment; index==N -> GET_SUM, otherwise GET_LO.
REQ-028 Checksum = 8-bit sum, modulo 256, of all 2N data bytes; sync, length and checksum bytes are excluded.
REQ-029 GET_SUM match -> DONE: boot_mode 0 and boot_done=1 in the same cycle; boot_done lasts one cycle.
REQ-030 GET_SUM mismatch -> set boot_err, go to WAIT_SYNC; boot_mode stays 1; already-written words are not rolled back.
REQ-031 DONE SHALL ignore all further uart_rx activity until reset.
REQ-032 An inter-byte timeout SHALL be counted in GET_LEN, GET_LO, GET_HI and GET_SUM, reset on each byte strobe.
REQ-033 Gap > TIMEOUT_CLKS -> set boot_err, go to WAIT_SYNC.
REQ-034 A new successful frame SHALL NOT clear boot_err; only reset clears it.
REQ-035 mem_wre SHALL never be asserted outside the REQ-026 write cycle or while boot_mode=0.

Reset
REQ-036 rst_n=0 at a clock edge SHALL force: FSM WAIT_SYNC, receiver idle, mem_wre 0, mem_ad 0, mem_din 0, boot_mode 1, boot_done 0, boot_err 0, counters 0.
REQ-037 Reset mid-frame or mid-byte SHALL abandon the partial frame; the next frame SHALL load normally starting at address 0.
REQ-038 Reset after DONE SHALL re-enter boot_mode=1 and accept a new frame.

Verification (CLK_HZ=1000000, BAUD=100000, CLKS_PER_BIT=10, TIMEOUT_CLKS=500)
REQ-039 Send 55 02 A1 00 78 00 19 -> writes (0,0x00A1), (1,0x0078); then boot_done pulse, boot_mode 0, boot_err 0.
REQ-040 Send 55 01 34 12 00 -> write (0,0x1234); boot_err 1; boot_mode 1.
REQ-041 Then send 55 01 34 12 46 -> load succeeds; boot_err stays 1.
REQ-042 Send 55 00 -> boot_err 1; no write.
REQ-043 Send 3-cycle low glitch on uart_rx -> no byte strobe, no state change.
REQ-044 Send byte with stop bit 0 -> boot_err 1, FSM in WAIT_SYNC.
REQ-045 Send 55 02 01 -> 600-cycle silence -> boot_err 1; a fresh valid frame loads from address 0.
REQ-046 Assert rst_n=0 during a data byte -> all outputs at reset values; next frame 55 01 FF FF FE succeeds with write (0,0xFFFF).
